// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the main-memory port arbiter.
// Owner encoding doubles as the requester index used by the picker.
package mem_port_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } arb_owner_t;

  function automatic arb_owner_t owner_of(input logic [1:0] gnt);
    return (gnt == 2'b10) ? OWN_DC : OWN_IC;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the icache, dcache, memory and status signals around the arbiter.
// master = environment (caches + memory), slave = the arbiter itself.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = mem_port_arbiter_pkg::ADDR_W,
  parameter int LINE_W = mem_port_arbiter_pkg::LINE_W
);
  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_done;
  logic [LINE_W-1:0] ic_rdata;
  logic              dc_req;
  logic              dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [LINE_W-1:0] dc_wdata;
  logic              dc_done;
  logic [LINE_W-1:0] dc_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_done;
  logic [LINE_W-1:0] mem_rdata;
  logic              busy;
  logic              owner;

  modport master (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_done, mem_rdata,
    input  ic_done, ic_rdata, dc_done, dc_rdata, mem_req, mem_we, mem_addr, mem_wdata,
    input  busy, owner
  );

  modport slave (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_done, mem_rdata,
    output ic_done, ic_rdata, dc_done, dc_rdata, mem_req, mem_we, mem_addr, mem_wdata,
    output busy, owner
  );
endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way alternating-priority picker: on a tie the requester that did not
// win last time is granted. Index 0 = icache, 1 = dcache.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Grant selection
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises icache fills and dcache fills/write-backs onto one memory line
// port, one transaction at a time, with alternating priority on ties.
module mem_port_arbiter #(
  parameter int ADDR_W = mem_port_arbiter_pkg::ADDR_W,
  parameter int LINE_W = mem_port_arbiter_pkg::LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);
  import mem_port_arbiter_pkg::*;

  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'((1 << OFF_W) - 1));

  arb_state_t        state_r;
  arb_state_t        state_next_s;
  arb_owner_t        owner_r;
  arb_owner_t        last_r;
  logic              we_r;
  logic              mem_req_r;
  logic              busy_r;
  logic              ic_done_r;
  logic              dc_done_r;
  logic [ADDR_W-1:0] addr_r;
  logic [LINE_W-1:0] wdata_r;
  logic [LINE_W-1:0] ic_rdata_r;
  logic [LINE_W-1:0] dc_rdata_r;
  logic [1:0]        gnt_s;
  logic              grant_s;
  logic [ADDR_W-1:0] sel_addr_s;

  rr_pick2 u_pick (
    .req  ({bus.dc_req, bus.ic_req}),
    .last (last_r == OWN_DC),
    .gnt  (gnt_s)
  );

  // Next-state and grant decode; requests only matter in IDLE
  always_comb begin
    state_next_s = state_r;
    grant_s      = 1'b0;
    sel_addr_s   = bus.ic_addr;
    if (state_r == ARB_IDLE) grant_s = (gnt_s != 2'b00);
    else                     grant_s = 1'b0;
    if (gnt_s[1]) sel_addr_s = bus.dc_addr;
    else          sel_addr_s = bus.ic_addr;
    case (state_r)
      ARB_IDLE:  state_next_s = grant_s ? ARB_ISSUE : ARB_IDLE;
      ARB_ISSUE: state_next_s = ARB_WAIT;
      ARB_WAIT:  state_next_s = bus.mem_done ? ARB_RESP : ARB_WAIT;
      ARB_RESP:  state_next_s = ARB_IDLE;
      default:   state_next_s = ARB_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ARB_IDLE;
    else     state_r <= state_next_s;
  end

  // Registered outputs, latched command and captured read lines
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_r    <= OWN_IC;
      last_r     <= OWN_IC;
      we_r       <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
      ic_rdata_r <= '0;
      dc_rdata_r <= '0;
      mem_req_r  <= 1'b0;
      busy_r     <= 1'b0;
      ic_done_r  <= 1'b0;
      dc_done_r  <= 1'b0;
    end else begin
      mem_req_r <= (state_next_s == ARB_ISSUE);
      busy_r    <= (state_next_s != ARB_IDLE);
      ic_done_r <= (state_next_s == ARB_RESP) && (owner_r == OWN_IC);
      dc_done_r <= (state_next_s == ARB_RESP) && (owner_r == OWN_DC);
      if (grant_s) begin
        owner_r <= owner_of(gnt_s);
        we_r    <= gnt_s[1] & bus.dc_we;
        addr_r  <= sel_addr_s & LINE_MASK;
        wdata_r <= gnt_s[1] ? bus.dc_wdata : '0;
      end
      // Writes complete without touching either read line
      if ((state_r == ARB_WAIT) && bus.mem_done) begin
        last_r <= owner_r;
        if (!we_r && (owner_r == OWN_IC)) ic_rdata_r <= bus.mem_rdata;
        if (!we_r && (owner_r == OWN_DC)) dc_rdata_r <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_req   = mem_req_r;
  assign bus.mem_we    = we_r;
  assign bus.mem_addr  = addr_r;
  assign bus.mem_wdata = wdata_r;
  assign bus.ic_done   = ic_done_r;
  assign bus.ic_rdata  = ic_rdata_r;
  assign bus.dc_done   = dc_done_r;
  assign bus.dc_rdata  = dc_rdata_r;
  assign bus.busy      = busy_r;
  assign bus.owner     = (owner_r == OWN_DC);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus predicts the command order,
// a monitor acts as main memory and checks commands, completions and timing.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         own;
    logic         we;
    logic [31:0]  addr;
    logic [127:0] wdata;
    int           exp_cyc;
  } cmd_t;

  typedef struct {
    logic own;
    int   exp_cyc;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Controls owned by the stimulus process
  logic         mem_auto = 1'b1;
  int           fix_lat = 0;
  logic         fix_rdata_en = 1'b0;
  logic [127:0] fix_rdata = '0;
  int           stale_at = -1;
  int           tmo_n = 0;
  int           idle_n = 0;
  int           end_n = 0;
  logic         model_last = 1'b0;

  // State owned by the monitor process
  int           n_tests = 0;
  int           n_fail = 0;
  int           cnt = 0;
  int           tmo_seen = 0;
  int           idle_seen = 0;
  int           end_seen = 0;
  cmd_t         cur;
  cmd_t         c;
  rsp_t         rr;
  logic [127:0] pend_rdata;
  logic [127:0] model_rdata [2];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got event expected none at cycle %0d", name, cyc);
  endtask

  // Monitor: plays main memory and scores every DUT output
  always @(negedge clk) begin
    bus.mem_done = 1'b0;
    if (rst) begin
      cnt = 0;
      model_rdata[0] = '0;
      model_rdata[1] = '0;
      chk("reset_ctrl", 128'({bus.ic_done, bus.dc_done, bus.mem_req, bus.mem_we, bus.busy, bus.owner}), 128'(6'b0));
      chk("reset_addr", 128'(bus.mem_addr), 128'(32'h0));
      chk("reset_wdata", bus.mem_wdata, 128'h0);
      chk("reset_rdata", 128'(bus.ic_rdata | bus.dc_rdata), 128'h0);
    end else begin
      if (cyc == stale_at) begin
        bus.mem_done  = 1'b1;
        bus.mem_rdata = {4{32'hDEAD_BEEF}};
      end
      if (cnt > 0) begin
        chk("wait_addr", 128'(bus.mem_addr), 128'(cur.addr));
        chk("wait_we", 128'(bus.mem_we), 128'(cur.we));
        chk("wait_req_low", 128'(bus.mem_req), 128'(1'b0));
        cnt = cnt - 1;
        if (cnt == 0) begin
          bus.mem_done  = 1'b1;
          bus.mem_rdata = pend_rdata;
          if (!cur.we) model_rdata[cur.own] = pend_rdata;
          rr.own     = cur.own;
          rr.exp_cyc = cyc + 1;
          rsp_q.push_back(rr);
        end
      end else if (bus.mem_req) begin
        if (cmd_q.size() == 0) flag_fail("unexpected_mem_req");
        else begin
          c = cmd_q.pop_front();
          chk("issue_addr", 128'(bus.mem_addr), 128'(c.addr));
          chk("issue_we", 128'(bus.mem_we), 128'(c.we));
          chk("issue_owner", 128'(bus.owner), 128'(c.own));
          if (c.we) chk("issue_wdata", bus.mem_wdata, c.wdata);
          if (c.exp_cyc >= 0) chk("issue_cycle", 128'(cyc), 128'(c.exp_cyc));
          if (mem_auto) begin
            cur        = c;
            cnt        = (fix_lat > 0) ? fix_lat : int'($urandom_range(1, 5));
            pend_rdata = fix_rdata_en ? fix_rdata : {$urandom, $urandom, $urandom, $urandom};
          end
        end
      end
      if (bus.ic_done || bus.dc_done) begin
        if (rsp_q.size() == 0) flag_fail("unexpected_done");
        else begin
          rr = rsp_q.pop_front();
          chk("done_owner", 128'({bus.ic_done, bus.dc_done}), 128'(rr.own ? 2'b01 : 2'b10));
          chk("done_cycle", 128'(cyc), 128'(rr.exp_cyc));
          chk("ic_rdata", bus.ic_rdata, model_rdata[0]);
          chk("dc_rdata", bus.dc_rdata, model_rdata[1]);
          chk("resp_busy", 128'(bus.busy), 128'(1'b1));
        end
      end
      if (idle_n != idle_seen) begin
        idle_seen = idle_n;
        chk("idle_busy", 128'(bus.busy), 128'(1'b0));
        chk("idle_owner", 128'(bus.owner), 128'(model_last));
      end
    end
    if (tmo_n != tmo_seen) begin
      tmo_seen = tmo_n;
      flag_fail("round_timeout");
    end
    if (end_n != end_seen) begin
      end_seen = end_n;
      chk("cmd_q_drained", 128'(cmd_q.size()), 128'(0));
      chk("rsp_q_drained", 128'(rsp_q.size()), 128'(0));
    end
  end

  task automatic run_round(input logic do_ic, input logic do_dc, input logic [31:0] ia,
                           input logic [31:0] da, input logic dwe, input logic [127:0] dwd,
                           input logic ic_drop);
    cmd_t ci;
    cmd_t cd;
    int   r;
    int   n;
    logic ic_pend;
    logic dc_pend;
    r = cyc;
    ci.own = 1'b0; ci.we = 1'b0; ci.addr = ia & 32'hFFFF_FFF0; ci.wdata = '0;  ci.exp_cyc = -1;
    cd.own = 1'b1; cd.we = dwe;  cd.addr = da & 32'hFFFF_FFF0; cd.wdata = dwd; cd.exp_cyc = -1;
    if (do_ic && do_dc) begin
      if (model_last == 1'b0) begin
        cd.exp_cyc = r + 1;
        cmd_q.push_back(cd);
        cmd_q.push_back(ci);
        model_last = 1'b0;
      end else begin
        ci.exp_cyc = r + 1;
        cmd_q.push_back(ci);
        cmd_q.push_back(cd);
        model_last = 1'b1;
      end
    end else if (do_ic) begin
      ci.exp_cyc = r + 1;
      cmd_q.push_back(ci);
      model_last = 1'b0;
    end else if (do_dc) begin
      cd.exp_cyc = r + 1;
      cmd_q.push_back(cd);
      model_last = 1'b1;
    end
    bus.ic_req   = do_ic;
    bus.ic_addr  = ia;
    bus.dc_req   = do_dc;
    bus.dc_we    = dwe;
    bus.dc_addr  = da;
    bus.dc_wdata = dwd;
    ic_pend = do_ic;
    dc_pend = do_dc;
    n = 0;
    while ((ic_pend || dc_pend) && (n < 200)) begin
      @(negedge clk);
      n++;
      if (ic_drop && (n == 2)) bus.ic_req = 1'b0;
      if (bus.ic_done) begin ic_pend = 1'b0; bus.ic_req = 1'b0; end
      if (bus.dc_done) begin dc_pend = 1'b0; bus.dc_req = 1'b0; end
    end
    if (ic_pend || dc_pend) begin
      tmo_n++;
      bus.ic_req = 1'b0;
      bus.dc_req = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    idle_n++;
    @(negedge clk);
  endtask

  initial begin
    int r;
    cmd_t cr;
    bus.ic_req    = 1'b0;
    bus.ic_addr   = '0;
    bus.dc_req    = 1'b0;
    bus.dc_we     = 1'b0;
    bus.dc_addr   = '0;
    bus.dc_wdata  = '0;
    bus.mem_done  = 1'b0;
    bus.mem_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Lone icache fill, latency 3, known line
    fix_lat = 3; fix_rdata_en = 1'b1; fix_rdata = {16{8'hA5}};
    run_round(1'b1, 1'b0, 32'h0000_1234, 32'h0, 1'b0, 128'h0, 1'b0);

    // Dcache write-back; dcache read line must not move
    fix_lat = 2; fix_rdata_en = 1'b0;
    run_round(1'b0, 1'b1, 32'h0, 32'h8000_0040, 1'b1, 128'h0123456789ABCDEF0123456789ABCDEF, 1'b0);

    // Icache request dropped while waiting on memory
    fix_lat = 4;
    run_round(1'b1, 1'b0, 32'h0000_2ABC, 32'h0, 1'b0, 128'h0, 1'b1);

    // Reset while waiting, then a stale memory completion
    fix_lat = 0; mem_auto = 1'b0;
    r = cyc;
    cr.own = 1'b0; cr.we = 1'b0; cr.addr = 32'h0000_3000; cr.wdata = '0; cr.exp_cyc = r + 1;
    cmd_q.push_back(cr);
    bus.ic_req = 1'b1; bus.ic_addr = 32'h0000_300C;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.ic_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_last = 1'b0;
    stale_at = cyc + 2;
    repeat (4) @(negedge clk);
    idle_n++;
    @(negedge clk);
    mem_auto = 1'b1;

    // Fresh reset, then both requesters held: expect DC, IC, DC, IC
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_last = 1'b0;
    run_round(1'b1, 1'b1, 32'h0000_1100, 32'h0000_2200, 1'b0, 128'h0, 1'b0);
    run_round(1'b1, 1'b1, 32'h0000_3300, 32'h0000_4400, 1'b1, {4{32'h5A5A_0F0F}}, 1'b0);

    // Randomised rounds
    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = int'($urandom_range(1, 3));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_round(kind[0], kind[1], $urandom, $urandom, 1'($urandom_range(0, 1)),
                {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    end

    end_n++;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected $finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
